rx_frame_loader: RTL

Byte-stream frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle `RxD_data` / `RxD_data_ready` byte strobes, parses a framed write command (sync, command, address, length, payload, checksum) and issues byte writes into the processor's data or instruction memory. Host software uses it to load SAD operand images over the serial link; it reports per-frame success or failure.

---
 rtl/rx_frame_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rx_frame_loader.sv
// rtl/rx_frame_loader.sv - serial frame decoder issuing byte writes into processor memory
module rx_frame_loader #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int GAP_W = $clog2(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t            state, state_nx;
    logic [7:0]        addr_hi, addr_hi_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [8:0]        remain, remain_nx;
    logic [7:0]        csum, csum_nx;
    logic [GAP_W-1:0]  gap, gap_nx;

    logic              we_nx;
    logic [ADDR_W-1:0] waddr_nx;
    logic [7:0]        wdata_nx;
    logic              done_nx;
    logic              err_nx;
    logic [1:0]        code_nx;
    logic              timeout_hit;

    // An arriving byte always beats the idle-gap limit in the same cycle.
    assign timeout_hit = (state != S_IDLE) && !rx_valid && (gap == GAP_LAST);
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nx   = state;
        addr_hi_nx = addr_hi;
        addr_nx    = addr;
        remain_nx  = remain;
        csum_nx    = csum;
        we_nx      = 1'b0;
        waddr_nx   = mem_addr;
        wdata_nx   = mem_wdata;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        code_nx    = err_code;
        gap_nx     = (rx_valid || state == S_IDLE || timeout_hit) ? '0 : gap + 1'b1;

        if (timeout_hit) begin
            err_nx   = 1'b1;
            code_nx  = 2'b11;
            state_nx = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        csum_nx  = 8'h00;
                        state_nx = S_CMD;
                    end
                end
                S_CMD: begin
                    csum_nx = csum ^ rx_data;
                    if (rx_data == CMD_WRITE) begin
                        state_nx = S_ADDR_HI;
                    end else begin
                        err_nx   = 1'b1;
                        code_nx  = 2'b01;
                        state_nx = S_IDLE;
                    end
                end
                S_ADDR_HI: begin
                    csum_nx    = csum ^ rx_data;
                    addr_hi_nx = rx_data;
                    state_nx   = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    csum_nx  = csum ^ rx_data;
                    addr_nx  = ADDR_W'({addr_hi, rx_data});
                    state_nx = S_LEN;
                end
                S_LEN: begin
                    csum_nx   = csum ^ rx_data;
                    remain_nx = {(rx_data == 8'h00), rx_data};
                    state_nx  = S_DATA;
                end
                S_DATA: begin
                    csum_nx   = csum ^ rx_data;
                    we_nx     = 1'b1;
                    waddr_nx  = addr;
                    wdata_nx  = rx_data;
                    addr_nx   = addr + ADDR_W'(1);
                    remain_nx = remain - 9'd1;
                    if (remain == 9'd1) begin
                        state_nx = S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_data == csum) begin
                        done_nx = 1'b1;
                    end else begin
                        err_nx  = 1'b1;
                        code_nx = 2'b10;
                    end
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_hi    <= 8'h00;
            addr       <= '0;
            remain     <= 9'd0;
            csum       <= 8'h00;
            gap        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            state      <= state_nx;
            addr_hi    <= addr_hi_nx;
            addr       <= addr_nx;
            remain     <= remain_nx;
            csum       <= csum_nx;
            gap        <= gap_nx;
            mem_we     <= we_nx;
            mem_addr   <= waddr_nx;
            mem_wdata  <= wdata_nx;
            frame_done <= done_nx;
            frame_err  <= err_nx;
            err_code   <= code_nx;
        end
    end

endmodule
